mant_mul_seq: RTL and testbench
===============================

MANT_MUL_SEQ -- requirements
Module: mant_mul_seq

Interface
REQ-001 Parameter: WIDTH, 9, operand mantissa width; 2*WIDTH SHALL equal 18 to match the shared adder18 datapath.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand pair present.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  multiplicand mantissa, unsigned.
REQ-007 Port: b  input  WIDTH  multiplier mantissa, unsigned.
REQ-008 Port: out_valid  output  1  product available.
REQ-009 Port: out_ready  input  1  consumer accepts product.
REQ-010 Port: p  output  2*WIDTH  unsigned product a*b.
REQ-011 Port: busy  output  1  high in RUN or DONE.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, latch mcand={9'b0,a}, mplr=b, acc=0, cnt=0; go to RUN.
REQ-014 RUN: each edge, if mplr[0]=1 then acc<=adder18(acc,mcand), else acc unchanged; mcand<<=1; mplr>>=1; cnt<=cnt+1.
REQ-015 RUN SHALL last exactly WIDTH (9) edges regardless of operand values; no early termination on zero.
REQ-016 After the 9th RUN edge, state SHALL be DONE, with out_valid=1 and p=acc.
REQ-017 Latency SHALL be fixed: out_valid asserts 9 edges after the accepting edge.
REQ-018 DONE: p and out_valid SHALL hold stable while out_ready=0.
REQ-019 DONE with out_ready=1: go to IDLE; in_ready=1 on the following cycle.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no operand capture.
REQ-021 Adder carry-out SHALL NOT be needed: maximum product 511*511=261121 < 2^18; acc is 18 bits with no saturation.
REQ-022 mcand bits shifted beyond bit 17 SHALL be discarded; they cannot affect acc for valid WIDTH.
REQ-023 p SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, acc=0, mcand=0, mplr=0, cnt=0, out_valid=0, p=0, busy=0, in_ready=1 after deassertion.
REQ-025 Reset during RUN or DONE SHALL discard the operation; no product is emitted afterwards.
REQ-026 rst_n deassertion SHALL be the only exit from reset; the first acceptance is possible on the first edge with rst_n high.

Structure
REQ-027 Shared package mul_pkg SHALL hold the WIDTH constant, the state enum typedef (IDLE/RUN/DONE) and the counter width constant (4 bits).
REQ-028 Exactly one sub-module SHALL be instantiated: the existing adder18, performing every accumulation; no other "+" on the datapath except cnt increment.

Verification
REQ-029 a=511, b=511 accepted at edge 0 -> out_valid at edge 9, p=261121.
REQ-030 a=0, b=300 and a=300, b=0 -> p=0, still 9-edge latency each.
REQ-031 a=1, b=1 then a=5, b=3 back-to-back, out_ready=1 -> p=1 then p=15; in_ready low throughout RUN/DONE, high one cycle after each handoff.
REQ-032 a=200, b=100 with out_ready=0 for 5 cycles after out_valid -> p=20000 stable and out_valid high all 5 cycles; IDLE one cycle after out_ready=1.
REQ-033 in_valid with a=7, b=7 pulsed during RUN of a=3, b=3 -> p=9; the second pair is not captured.
REQ-034 rst_n low at RUN edge 4 of a=100, b=100 -> all outputs 0 immediately; after release, no out_valid until a new acceptance.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential mantissa multiplier.
// Holds the operand width, the iteration counter width and the FSM state encoding.
// No logic lives here; everything is elaboration-time only.
package mul_pkg;

    localparam int WIDTH = 9;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder18.sv
// 18-bit unsigned adder shared by the mantissa datapaths.
// Purely combinational, zero latency.
// No handshake; the carry-out is dropped because callers guarantee it is never set.
module adder18 (
    input  logic [17:0] a_i,
    input  logic [17:0] b_i,
    output logic [17:0] s_o
);

    assign s_o = a_i + b_i;

endmodule

// File: rtl/mant_mul_seq.sv
// Shift-and-add unsigned mantissa multiplier, one multiplier bit per clock.
// Latency: product valid exactly WIDTH edges after the accepting edge.
// Backpressure: in_ready only in IDLE; product held stable in DONE until out_ready.
module mant_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PWL = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [PWL-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q,  mplr_d;
    logic [PWL-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PWL-1:0]   sum;

    // Every accumulation goes through the shared adder.
    adder18 u_adder (
        .a_i (acc_q),
        .b_i (mcand_q),
        .s_o (sum)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RUN always lasts WIDTH edges, no early exit on zero operands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Outputs: product gated to zero outside DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        p         = out_valid ? acc_q : '0;
    end

    // Datapath next state: capture in IDLE, shift-and-add in RUN, hold otherwise.
    always_comb begin
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = {{(PWL-WIDTH){1'b0}}, a};
                    mplr_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (mplr_q[0]) begin
                    acc_d = sum;
                end
                // Bits shifted past the top are dropped; they never reach acc for WIDTH-bit operands.
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq with a queue scoreboard of expected products.
module tb_mant_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  a;
    logic [8:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] p;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [17:0] sb[$];

    mant_mul_seq #(.WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single edge and record the expected product.
    task automatic send(input logic [8:0] av, input logic [8:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        sb.push_back(18'(av) * 18'(bv));
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_exp(output logic [17:0] e);
        if (sb.size() == 0) e = 18'h3ffff;
        else e = sb.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        total_cnt++;
        if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 18'd0})
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b p=%0d want rdy=1 vld=0 busy=0 p=0",
                     in_ready, out_valid, busy, p);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_max();
        int lat; logic [17:0] e;
        send(9'd511, 9'd511);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL max_run_flags: got rdy=%b busy=%b want rdy=0 busy=1", in_ready, busy);
        else pass_cnt++;
        wait_out(lat);
        pop_exp(e);
        total_cnt++;
        if (lat != 9) $display("FAIL max_latency: got %0d want 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (p !== e || e !== 18'd261121) $display("FAIL max_product: got %0d want %0d", p, e);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 18'd0)
            $display("FAIL max_handoff: got rdy=%b vld=%b p=%0d want 1 0 0", in_ready, out_valid, p);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int lat; logic [17:0] e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send(9'd0, 9'd300);
            else        send(9'd300, 9'd0);
            wait_out(lat);
            pop_exp(e);
            total_cnt++;
            if (lat != 9) $display("FAIL zero_latency_%0d: got %0d want 9", k, lat);
            else pass_cnt++;
            total_cnt++;
            if (p !== e) $display("FAIL zero_product_%0d: got %0d want %0d", k, p, e);
            else pass_cnt++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [17:0] e; bit rdy_bad;
        logic [8:0] av[2] = '{9'd1, 9'd5};
        logic [8:0] bv[2] = '{9'd1, 9'd3};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send(av[k], bv[k]);
            rdy_bad = 1'b0;
            lat = 0;
            while (!out_valid && lat < 30) begin
                if (in_ready !== 1'b0) rdy_bad = 1'b1;
                tick();
                lat++;
            end
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            pop_exp(e);
            total_cnt++;
            if (p !== e || lat != 9)
                $display("FAIL b2b_product_%0d: got p=%0d lat=%0d want p=%0d lat=9", k, p, lat, e);
            else pass_cnt++;
            total_cnt++;
            if (rdy_bad) $display("FAIL b2b_ready_low_%0d: in_ready got 1 want 0 during RUN/DONE", k);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_%0d: got %b want 1", k, in_ready);
            else pass_cnt++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int lat; logic [17:0] e;
        send(9'd200, 9'd100);
        wait_out(lat);
        pop_exp(e);
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || p !== e || e !== 18'd20000)
                $display("FAIL stall_hold_%0d: got vld=%b p=%0d want vld=1 p=%0d", c, out_valid, p, e);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL stall_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_ignore_in_valid();
        int lat; logic [17:0] e; bit extra;
        send(9'd3, 9'd3);
        tick();
        a = 9'd7; b = 9'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        pop_exp(e);
        total_cnt++;
        if (p !== e || lat != 7) $display("FAIL ignore_product: got p=%0d lat=%0d want p=%0d lat=7", p, lat, e);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        extra = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid || busy) extra = 1'b1;
            tick();
        end
        total_cnt++;
        if (extra) $display("FAIL ignore_no_capture: got busy/out_valid 1 want 0");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [17:0] e; bit extra;
        send(9'd100, 9'd100);
        for (int c = 0; c < 3; c++) tick();
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        total_cnt++;
        if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 18'd0})
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b p=%0d want 1 0 0 0",
                     in_ready, out_valid, busy, p);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        extra = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) extra = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (extra) $display("FAIL midrun_no_output: got out_valid 1 want 0");
        else pass_cnt++;
        send(9'd13, 9'd17);
        wait_out(lat);
        pop_exp(e);
        total_cnt++;
        if (p !== e || lat != 9) $display("FAIL midrun_recover: got p=%0d lat=%0d want p=%0d lat=9", p, lat, e);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero();
        test_back_to_back();
        test_stall();
        test_ignore_in_valid();
        test_reset_mid_run();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d left want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
